// File: rtl/menu_idle_dimmer.sv
// Idle dimmer between the menu video generator and the VGA pins: fades the picture
// to a floor level after a period of no user activity, and back up on activity.
module menu_idle_dimmer_lane (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic [7:0] pix,
  input  logic [8:0] level,
  output logic [7:0] pix_out
);
  logic [16:0] prod;
  assign prod = {9'd0, pix} * {8'd0, level};

  // prod[16] cannot be set while level <= 256; the clamp only guards that bound
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) pix_out <= '0;
    else          pix_out <= prod[16] ? 8'hFF : prod[15:8];
endmodule

module menu_idle_dimmer #(
  parameter int CLK_HZ    = 50000000,
  parameter int TIMEOUT_S = 120,
  parameter int STEP      = 8,
  parameter int MIN_LEVEL = 32
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       de_in,
  input  logic       key_stb,
  input  logic [1:0] buttons,
  input  logic       osd_status,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic       hs_out,
  output logic       vs_out,
  output logic       de_out,
  output logic [8:0] level,
  output logic       dimmed
);
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 8;
  localparam int PS_W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SEC_W     = $clog2(TIMEOUT_S + 1);

  typedef enum logic [1:0] {ACTIVE, FADE_OUT, DIM, FADE_IN} state_t;
  typedef struct packed { logic hs; logic vs; logic de; } sync_t;

  state_t                state_q, state_nx;
  logic [8:0]            level_nx;
  logic [PS_W-1:0]       prescaler;
  logic [SEC_W-1:0]      idle_sec;
  logic                  key_stb_d, vs_d, primed;
  logic                  act, ft;
  logic [9:0]            lvl_dn, lvl_up;
  sync_t                 sync_q;
  logic [NUM_LANES-1:0][VEC_W-1:0] pix_in, pix_out;

  // edge detectors are masked until the first capture after reset
  assign act = (primed & (key_stb ^ key_stb_d)) | (|buttons) | osd_status;
  assign ft  = primed & vs_in & ~vs_d;

  assign lvl_dn = ({1'b0, level} < 10'(MIN_LEVEL + STEP)) ? 10'(MIN_LEVEL)
                                                          : {1'b0, level} - 10'(STEP);
  assign lvl_up = ({1'b0, level} + 10'(STEP) > 10'd256) ? 10'd256
                                                        : {1'b0, level} + 10'(STEP);

  always_comb begin
    state_nx = state_q;
    level_nx = level;
    case (state_q)
      ACTIVE:   if (!act && idle_sec == SEC_W'(TIMEOUT_S)) state_nx = FADE_OUT;
      FADE_OUT: if (act) state_nx = FADE_IN;
                else if (ft) begin
                  level_nx = lvl_dn[8:0];
                  if (lvl_dn == 10'(MIN_LEVEL)) state_nx = DIM;
                end
      DIM:      if (act) state_nx = FADE_IN;
      FADE_IN:  if (ft) begin
                  level_nx = lvl_up[8:0];
                  if (lvl_up == 10'd256) state_nx = ACTIVE;
                end
      default:  state_nx = ACTIVE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state_q   <= ACTIVE;
      level     <= 9'd256;
      dimmed    <= 1'b0;
      key_stb_d <= 1'b0;
      vs_d      <= 1'b0;
      primed    <= 1'b0;
    end else begin
      state_q   <= state_nx;
      level     <= level_nx;
      dimmed    <= (state_nx != ACTIVE);
      key_stb_d <= key_stb;
      vs_d      <= vs_in;
      primed    <= 1'b1;
    end

  // idle timer only runs while ACTIVE; any activity restarts it
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      prescaler <= '0;
      idle_sec  <= '0;
    end else if (state_q != ACTIVE || act) begin
      prescaler <= '0;
      idle_sec  <= '0;
    end else if (prescaler == PS_W'(CLK_HZ - 1)) begin
      prescaler <= '0;
      if (idle_sec != SEC_W'(TIMEOUT_S)) idle_sec <= idle_sec + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end

  assign pix_in = {b_in, g_in, r_in};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    menu_idle_dimmer_lane u_lane (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .pix     (pix_in[i]),
      .level   (level),
      .pix_out (pix_out[i])
    );
  end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else          sync_q <= '{hs: hs_in, vs: vs_in, de: de_in};

  assign r_out  = pix_out[0];
  assign g_out  = pix_out[1];
  assign b_out  = pix_out[2];
  assign hs_out = sync_q.hs;
  assign vs_out = sync_q.vs;
  assign de_out = sync_q.de;
endmodule
